// File: rtl/send_uart_pkg.sv
// ============================================================================
// Module      : send_uart_pkg
// Description : Shared types and constants for the send_uart_tx result
//               printer: formatter state encoding, ASCII constants and the
//               nibble-to-hex helper.
// Options     : SEND_UART_PARITY_EN (consumed by uart_tx_ser)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package send_uart_pkg;

    // Formatter states: fetch a byte, present a char, wait for it to go out.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CHAR = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] ZERO  = 8'h30;
    // 'A' (0x41) minus 10, so A_OFS + nibble lands on 'A'..'F'.
    localparam logic [7:0] A_OFS = 8'h37;

    // Two hex digits, CR, LF.
    localparam int CHARS_PER_RESULT = 4;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ZERO + {4'h0, nib};
        end
        return A_OFS + {4'h0, nib};
    endfunction

endpackage

`default_nettype wire

// File: rtl/send_uart_tx_if.sv
// ============================================================================
// Module      : send_uart_tx_if
// Description : Result-byte handshake between the calculator core (master)
//               and the UART result printer (slave). A byte transfers on a
//               clock edge where send_vld && send_rdy.
// Options     : none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface send_uart_tx_if;
    logic       send_vld;
    logic [7:0] send_data;
    logic       send_rdy;

    modport master (output send_vld, output send_data, input  send_rdy);
    modport slave  (input  send_vld, input  send_data, output send_rdy);
endinterface

`default_nettype wire

// File: rtl/uart_tx_ser.sv
// ============================================================================
// Module      : uart_tx_ser
// Description : UART bit serializer. Start bit, 8 data bits LSB first,
//               optional even parity, one stop bit; each bit lasts
//               CLKS_PER_BIT clocks. rdy_o is also high in the very last
//               clock of a stop bit so back-to-back frames have no gap, and
//               done_o fires two clocks before the frame ends so the
//               formatter has time to fetch the next char (even via LOAD).
// Options     : SEND_UART_PARITY_EN - insert even parity bit after d7
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_ser #(
    parameter int CLKS_PER_BIT = 100
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start_i,
    input  wire logic [7:0] data_i,
    output logic            rdy_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            tx_o
);

`ifdef SEND_UART_PARITY_EN
    localparam int c_frame_bits = 11;
`else
    localparam int c_frame_bits = 10;
`endif
    // Everything after the start bit lives in the shift register.
    localparam int c_shift_w = c_frame_bits - 1;
    localparam int c_cnt_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_done = c_cnt_w'(CLKS_PER_BIT - 3);
    localparam logic [3:0]         c_bit_last = 4'(c_frame_bits - 1);

    logic [c_cnt_w-1:0]   cnt_q;
    logic [3:0]           bit_q;
    logic [c_shift_w-1:0] shift_q;
    logic                 tx_q;
    logic                 active_q;
    logic                 w_bit_end;
    logic                 w_last_bit;
    logic [c_shift_w-1:0] w_frame;

`ifdef SEND_UART_PARITY_EN
    assign w_frame = {1'b1, ^data_i, data_i};
`else
    assign w_frame = {1'b1, data_i};
`endif

    assign w_bit_end  = (cnt_q == c_cnt_last);
    assign w_last_bit = (bit_q == c_bit_last);
    assign rdy_o      = !active_q || (w_last_bit && w_bit_end);
    assign done_o     = active_q && w_last_bit && (cnt_q == c_cnt_done);
    assign busy_o     = active_q;
    assign tx_o       = tx_q;

    // Baud counter and shift register; a start request overrides the tail
    // of the current stop bit so the next start bit follows seamlessly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            tx_q     <= 1'b1;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            tx_q     <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= w_frame;
        end else if (active_q) begin
            if (w_bit_end) begin
                cnt_q <= '0;
                if (w_last_bit) begin
                    active_q <= 1'b0;
                    tx_q     <= 1'b1;
                end else begin
                    bit_q   <= bit_q + 4'd1;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/send_uart_tx.sv
// ============================================================================
// Module      : send_uart_tx
// Description : Prints each SEND result byte on the UART as "HH\r\n".
//               A FIFO_DEPTH-entry FIFO absorbs back-to-back results; a
//               four-state formatter turns the head byte into four chars
//               and hands them to uart_tx_ser. ovf is a sticky drop flag.
// Options     : SEND_UART_PARITY_EN - even parity bit per char (11-bit frame)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module send_uart_tx
    import send_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    send_uart_tx_if.slave send_if,
    output logic          tx,
    output logic          busy,
    output logic          ovf
);

    localparam int c_clks_per_bit = CLK_HZ / BAUD;
    localparam int c_ptr_w        = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w        = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(FIFO_DEPTH);
    localparam logic [1:0]         c_idx_last = 2'(CHARS_PER_RESULT - 1);

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;
    logic               ovf_q;
    logic               w_rdy;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         hold_q, hold_d;
    logic               w_ser_start;
    logic               w_ser_rdy;
    logic               w_ser_done;
    logic               w_ser_busy;
    logic [7:0]         w_ser_char;

    assign w_rdy            = (count_q != c_full);
    assign w_empty          = (count_q == '0);
    assign w_push           = send_if.send_vld && w_rdy;
    assign w_pop            = (state_q == LOAD);
    assign send_if.send_rdy = w_rdy;
    assign ovf              = ovf_q;
    assign busy             = !w_empty || (state_q != IDLE) || w_ser_busy;

    // FIFO pointers and occupancy; push and pop together keep count steady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; stale entries are harmless because count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= send_if.send_data;
    end

    // Sticky overflow: a valid byte offered while the FIFO is full is lost.
    always_ff @(posedge clk) begin
        if (!rst_n)                         ovf_q <= 1'b0;
        else if (send_if.send_vld && !w_rdy) ovf_q <= 1'b1;
    end

    // Formatter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

    // Formatter next state: CHAR waits for the serializer to accept, WAIT
    // advances on done, and the last char chains straight into LOAD.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        w_ser_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!w_empty) state_d = LOAD;
            end
            LOAD: begin
                hold_d  = mem_q[rd_ptr_q];
                idx_d   = '0;
                state_d = CHAR;
            end
            CHAR: begin
                if (w_ser_rdy) begin
                    w_ser_start = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (w_ser_done) begin
                    if (idx_q == c_idx_last) begin
                        state_d = w_empty ? IDLE : LOAD;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = CHAR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Char selection for the current position within the result.
    always_comb begin
        w_ser_char = LF;
        case (idx_q)
            2'd0:    w_ser_char = hex_ascii(hold_q[7:4]);
            2'd1:    w_ser_char = hex_ascii(hold_q[3:0]);
            2'd2:    w_ser_char = CR;
            default: w_ser_char = LF;
        endcase
    end

    uart_tx_ser #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (w_ser_start),
        .data_i  (w_ser_char),
        .rdy_o   (w_ser_rdy),
        .done_o  (w_ser_done),
        .busy_o  (w_ser_busy),
        .tx_o    (tx)
    );

endmodule

`default_nettype wire

// File: tb/tb_send_uart_tx.sv
// ============================================================================
// Module      : tb_send_uart_tx
// Description : Scoreboard bench for send_uart_tx. Stimulus pushes the
//               hand-computed ASCII chars of each accepted result into a
//               queue; a UART receiver process decodes tx and pops/compares.
//               Start-bit cycle stamps are checked for latency and gaps.
// Options     : SEND_UART_PARITY_EN - expects 11-bit frames with even parity
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_send_uart_tx;

    localparam int CLK_HZ     = 100_000_000;
    localparam int BAUD       = 1_000_000;
    localparam int FIFO_DEPTH = 4;
    localparam int CPB        = CLK_HZ / BAUD;
`ifdef SEND_UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = CPB * FRAME_BITS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic busy;
    logic ovf;
    int   cyc   = 0;

    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    send_uart_tx_if send_if ();

    send_uart_tx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .send_if (send_if),
        .tx      (tx),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push_res(input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy === 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check("busy_timeout", busy, 1'b0);
    endtask

    // Every char is expected to start exactly one frame after the previous.
    task automatic check_starts(input string name, input int first, input int nchars);
        check({name, "_nchars"}, start_q.size(), nchars);
        for (int i = 0; i < nchars && i < start_q.size(); i++) begin
            check({name, "_start"}, start_q[i], first + i * FRAME_CLKS);
        end
        start_q.delete();
    endtask

    // UART receiver / scoreboard monitor.
    initial begin : p_monitor
        int                    st;
        logic                  ok;
        logic [FRAME_BITS-1:0] bits;
        logic [7:0]            ch;
        logic [7:0]            ex;
        forever begin
            tick();
            if (rst_n === 1'b1 && tx === 1'b0) begin
                st   = cyc;
                ok   = 1'b1;
                bits = '0;
                for (int k = 0; k < FRAME_BITS && ok; k++) begin
                    while (ok && cyc < st + k * CPB + CPB / 2) begin
                        tick();
                        if (rst_n !== 1'b1) ok = 1'b0;
                    end
                    bits[k] = tx;
                end
                if (ok) begin
                    ch = bits[8:1];
                    start_q.push_back(st);
                    check("start_bit", bits[0], 1'b0);
                    check("stop_bit", bits[FRAME_BITS-1], 1'b1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_char", ch, 8'h00);
                        if (ch == 8'h00) begin
                            n_errors++;
                            $display("FAIL unexpected_char: got 0x00 expected no char");
                        end
                    end else begin
                        ex = exp_q.pop_front();
                        check("char", ch, ex);
`ifdef SEND_UART_PARITY_EN
                        check("parity", bits[9], ^ex);
`endif
                    end
                end
            end
        end
    end

    initial begin : p_watchdog
        #(10 * 90_000);
        $display("FAIL watchdog: got cycle %0d required finish before 90000", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        int               a;
        int               n;
        logic [7:0]       v2 [4];
        logic [7:0]       v3 [6];

        v2 = '{8'h00, 8'hFF, 8'h0A, 8'h9C};
        v3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_if.send_vld  = 1'b0;
        send_if.send_data = 8'h00;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_tx", tx, 1'b1);
        check("rst_rdy", send_if.send_rdy, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single result 0x5B -> "5B\r\n"
        push_res(8'h35, 8'h42);
        a = cyc + 1;
        send_if.send_vld  = 1'b1;
        send_if.send_data = 8'h5B;
        tick();
        send_if.send_vld  = 1'b0;
        wait_until(a + 3 + 4 * FRAME_CLKS - 1);
        check("t1_busy_before_end", busy, 1'b1);
        tick();
        check("t1_busy_at_end", busy, 1'b0);
        check("t1_ovf", ovf, 1'b0);
        check("t1_queue_empty", exp_q.size(), 0);
        check_starts("t1", a + 3, 4);
        repeat (5) tick();

        // Back-to-back results on consecutive cycles
        push_res("0", "0");
        push_res("F", "F");
        push_res("0", "A");
        push_res("9", "C");
        a = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            check("t2_rdy", send_if.send_rdy, 1'b1);
            send_if.send_vld  = 1'b1;
            send_if.send_data = v2[i];
            tick();
        end
        send_if.send_vld = 1'b0;
        wait_idle(20 * FRAME_CLKS);
        check("t2_queue_empty", exp_q.size(), 0);
        check_starts("t2", a + 3, 16);
        repeat (5) tick();

        // Six writes: 5 accepted, 6th dropped; then refills while full
        push_res("1", "1");
        push_res("2", "2");
        push_res("3", "3");
        push_res("4", "4");
        push_res("5", "5");
        push_res("7", "7");
        push_res("8", "8");
        a = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            check("t3_rdy", send_if.send_rdy, (i < 5) ? 1'b1 : 1'b0);
            send_if.send_vld  = 1'b1;
            send_if.send_data = v3[i];
            tick();
        end
        send_if.send_vld = 1'b0;
        check("t3_ovf", ovf, 1'b1);
        check("t3_rdy_full", send_if.send_rdy, 1'b0);
        n = 0;
        while (send_if.send_rdy !== 1'b1 && n < 2 * 4 * FRAME_CLKS) begin
            tick();
            n++;
        end
        check("t3_rdy_timeout", send_if.send_rdy, 1'b1);
        send_if.send_vld  = 1'b1;
        send_if.send_data = 8'h77;
        tick();
        send_if.send_vld  = 1'b0;
        check("t3_rdy_refull", send_if.send_rdy, 1'b0);
        // Hold a byte across the next pop while full: exactly one copy lands.
        send_if.send_vld  = 1'b1;
        send_if.send_data = 8'h88;
        n = 0;
        while (send_if.send_rdy !== 1'b1 && n < 2 * 4 * FRAME_CLKS) begin
            tick();
            n++;
        end
        check("t5_rdy_timeout", send_if.send_rdy, 1'b1);
        tick();
        send_if.send_vld = 1'b0;
        wait_idle(40 * FRAME_CLKS);
        check("t3_queue_empty", exp_q.size(), 0);
        check_starts("t3", a + 3, 28);
        repeat (5) tick();

        // Reset during d3 of the second char
        push_res("A", "5");
        a = cyc + 1;
        send_if.send_vld  = 1'b1;
        send_if.send_data = 8'hA5;
        tick();
        send_if.send_vld = 1'b0;
        wait_until(a + 3 + FRAME_CLKS + 4 * CPB + 40);
        rst_n = 1'b0;
        tick();
        check("t4_tx", tx, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_ovf", ovf, 1'b0);
        check("t4_rdy", send_if.send_rdy, 1'b1);
        check("t4_first_char_seen", exp_q.size(), 3);
        tick();
        exp_q.delete();
        start_q.delete();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t4_tx_idle", tx, 1'b1);

        // Fresh result after the aborted frame
        push_res("1", "2");
        a = cyc + 1;
        send_if.send_vld  = 1'b1;
        send_if.send_data = 8'h12;
        tick();
        send_if.send_vld = 1'b0;
        wait_idle(6 * FRAME_CLKS);
        check("t4_queue_empty", exp_q.size(), 0);
        check_starts("t4", a + 3, 4);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
